// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state codes,
// ALU operation codes, mux select codes, opcode/funct constants and the
// decode-stage dispatch function.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MA   = 4'd2,
    S_MRD  = 4'd3,
    S_LWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REXE = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_BNE  = 4'd9,
    S_J    = 4'd10,
    S_IEXE = 4'd11,
    S_IWB  = 4'd12
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // Decode-stage dispatch; S_IF doubles as "opcode not recognised".
  function automatic state_t id_dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                                  id_dispatch = S_MA;
      OP_RTYPE:                                      id_dispatch = S_REXE;
      OP_BEQ:                                        id_dispatch = S_BEQ;
      OP_BNE:                                        id_dispatch = S_BNE;
      OP_J:                                          id_dispatch = S_J;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:    id_dispatch = S_IEXE;
      default:                                       id_dispatch = S_IF;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU operation decoder: R-type funct and I-type opcode to ALU_operation
// and immediate extension mode. Shift functs (SLL/SRL) are decoded only
// when the build defines MCPU_SHIFT_EN; otherwise they report invalid.
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] r_op,
  output logic       r_valid,
  output logic       r_shift,
  output logic [3:0] i_op,
  output logic       i_zext
);

`ifdef MCPU_SHIFT_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
`endif

  // R-type funct decode; r_shift asks the FSM to route shamt into operand A.
  always_comb begin
    r_op    = ALU_AND;
    r_valid = 1'b0;
    r_shift = 1'b0;
    case (funct)
      F_ADD: begin r_op = ALU_ADD; r_valid = 1'b1; end
      F_SUB: begin r_op = ALU_SUB; r_valid = 1'b1; end
      F_AND: begin r_op = ALU_AND; r_valid = 1'b1; end
      F_OR:  begin r_op = ALU_OR;  r_valid = 1'b1; end
      F_XOR: begin r_op = ALU_XOR; r_valid = 1'b1; end
      F_NOR: begin r_op = ALU_NOR; r_valid = 1'b1; end
      F_SLT: begin r_op = ALU_SLT; r_valid = 1'b1; end
      F_SLL: begin
        if (SHIFT_EN) begin
          r_op    = ALU_SLL;
          r_valid = 1'b1;
          r_shift = 1'b1;
        end
      end
      F_SRL: begin
        if (SHIFT_EN) begin
          r_op    = ALU_SRL;
          r_valid = 1'b1;
          r_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Immediate-type decode: logical ops zero-extend, arithmetic ops sign-extend.
  always_comb begin
    i_op   = ALU_ADD;
    i_zext = 1'b0;
    case (opcode)
      OP_ADDI: i_op = ALU_ADD;
      OP_SLTI: i_op = ALU_SLT;
      OP_ANDI: begin i_op = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_op = ALU_OR;  i_zext = 1'b1; end
      OP_XORI: begin i_op = ALU_XOR; i_zext = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS-style control unit. One FSM sequences fetch, decode,
// memory, execute and write-back; all datapath controls are Moore/Mealy
// decodes of the current state. While rst is high every write strobe is
// masked so an aborted instruction leaves no side effects.
// Optional build macro: MCPU_SHIFT_EN (SLL/SRL in R-type execute).
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic [3:0] ALU_operation,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZext,
  output logic [1:0] PCSource,
  output logic       PC_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_reg, state_next;
  logic [3:0] r_op, i_op;
  logic       r_valid, r_shift, i_zext;
  logic       pc_en_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  mcpu_alu_dec u_alu_dec (
    .opcode  (opcode),
    .funct   (funct),
    .r_op    (r_op),
    .r_valid (r_valid),
    .r_shift (r_shift),
    .i_op    (i_op),
    .i_zext  (i_zext)
  );

  // State register; reset always restarts at instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IF;
    else     state_reg <= state_next;
  end

  // Next-state and per-state control decode; every output defaults to 0.
  always_comb begin
    state_next    = S_IF;
    ALU_operation = ALU_AND;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_REG;
    ImmZext       = 1'b0;
    PCSource      = PCSRC_ALU;
    pc_en_raw     = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    case (state_reg)
      S_IF: begin
        MemRead       = 1'b1;
        ALUSrcB       = SRCB_FOUR;
        ALU_operation = ALU_ADD;
        ir_write_raw  = MIO_ready;
        pc_en_raw     = MIO_ready;
        state_next    = MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB       = SRCB_BOFF;
        ALU_operation = ALU_ADD;
        state_next    = id_dispatch(opcode);
        illegal_raw   = (id_dispatch(opcode) == S_IF);
      end
      S_MA: begin
        ALUSrcA       = SRCA_REG;
        ALUSrcB       = SRCB_IMM;
        ALU_operation = ALU_ADD;
        case (opcode)
          OP_LW:   state_next = S_MRD;
          OP_SW:   state_next = S_MWR;
          default: state_next = S_IF;
        endcase
      end
      S_MRD: begin
        IorD       = 1'b1;
        MemRead    = 1'b1;
        state_next = MIO_ready ? S_LWB : S_MRD;
      end
      S_MWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = MIO_ready ? S_IF : S_MWR;
      end
      S_LWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
      end
      S_REXE: begin
        ALUSrcA       = r_shift ? SRCA_SHAMT : SRCA_REG;
        ALUSrcB       = SRCB_REG;
        ALU_operation = r_op;
        illegal_raw   = ~r_valid;
        state_next    = r_valid ? S_RWB : S_IF;
      end
      S_RWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA       = SRCA_REG;
        ALUSrcB       = SRCB_REG;
        ALU_operation = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        pc_en_raw     = (state_reg == S_BEQ) ? zero : ~zero;
      end
      S_J: begin
        PCSource  = PCSRC_JUMP;
        pc_en_raw = 1'b1;
      end
      S_IEXE: begin
        ALUSrcA       = SRCA_REG;
        ALUSrcB       = SRCB_IMM;
        ALU_operation = i_op;
        ImmZext       = i_zext;
        state_next    = S_IWB;
      end
      S_IWB: begin
        reg_write_raw = 1'b1;
      end
      default: state_next = S_IF;
    endcase
  end

  // Write strobes are masked during reset so an aborted access cannot commit.
  assign PC_en    = pc_en_raw     & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign illegal  = illegal_raw   & ~rst;
  assign state    = state_reg;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed testbench for mcpu_ctrl. Inputs change 1 ns after posedge,
// outputs are sampled on negedge. Honors MCPU_SHIFT_EN for the shift case.
module tb_mcpu_ctrl;
  logic       clk = 1'b0;
  logic       rst, zero, MIO_ready;
  logic [5:0] opcode, funct;
  logic [3:0] ALU_operation, state;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource;
  logic       ImmZext, PC_en, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, illegal;
  int checks = 0;
  int errors = 0;

  mcpu_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .MIO_ready(MIO_ready), .ALU_operation(ALU_operation), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmZext(ImmZext), .PCSource(PCSource), .PC_en(PC_en),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic adv;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // From IF, fetch one instruction and land in ID.
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; MIO_ready = 1'b1; zero = 1'b0;
    adv;
    MIO_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; MIO_ready = 1'b1; opcode = 6'b000010; funct = 6'd0; zero = 1'b0;
    adv; smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if ({IRWrite, PC_en, MemWrite, RegWrite, illegal} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b exp 00000", {IRWrite, PC_en, MemWrite, RegWrite, illegal}); end
    $display("reset: state=%0d strobes=%b", state, {IRWrite, PC_en, MemWrite, RegWrite, illegal});
  endtask

  task automatic test_fetch;
    rst = 1'b1; MIO_ready = 1'b0; opcode = 6'b000010;
    adv;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MIO_ready = (i == 3);
      smp;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_state[%0d] got %0d exp 0", i, state); end
      checks++; if (IRWrite !== (i == 3) || PC_en !== (i == 3)) begin errors++; $display("FAIL fetch_wr[%0d] got IRWrite=%b PC_en=%b exp %b", i, IRWrite, PC_en, i == 3); end
      checks++; if ({MemRead, IorD, ALUSrcA, ALUSrcB, ALU_operation, PCSource} !== {1'b1, 1'b0, 2'd0, 2'd1, 4'd2, 2'd0}) begin errors++; $display("FAIL fetch_ctrl[%0d] got MemRead=%b IorD=%b A=%0d B=%0d op=%0d pcs=%0d", i, MemRead, IorD, ALUSrcA, ALUSrcB, ALU_operation, PCSource); end
      $display("fetch cycle %0d: state=%0d IRWrite=%b PC_en=%b", i, state, IRWrite, PC_en);
      adv;
    end
    MIO_ready = 1'b0;
    smp;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL fetch_to_id got %0d exp 1", state); end
    adv;
    smp;
    checks++; if (state !== 4'd10 || PCSource !== 2'd2 || PC_en !== 1'b1) begin errors++; $display("FAIL jump got state=%0d pcs=%0d PC_en=%b exp 10 2 1", state, PCSource, PC_en); end
    adv;
    smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL jump_to_if got %0d exp 0", state); end
  endtask

  task automatic test_rtype_sub;
    do_fetch(6'b000000, 6'b100010);
    smp;
    checks++; if (state !== 4'd1 || ALUSrcA !== 2'd0 || ALUSrcB !== 2'd3 || ALU_operation !== 4'd2 || illegal !== 1'b0) begin errors++; $display("FAIL sub_id got state=%0d A=%0d B=%0d op=%0d ill=%b", state, ALUSrcA, ALUSrcB, ALU_operation, illegal); end
    adv; smp;
    checks++; if (state !== 4'd6 || ALU_operation !== 4'd6 || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL sub_rexe got state=%0d op=%0d A=%0d B=%0d RegWrite=%b exp 6 6 1 0 0", state, ALU_operation, ALUSrcA, ALUSrcB, RegWrite); end
    adv; smp;
    checks++; if (state !== 4'd7 || RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin errors++; $display("FAIL sub_rwb got state=%0d RegWrite=%b RegDst=%b MemtoReg=%b exp 7 1 1 0", state, RegWrite, RegDst, MemtoReg); end
    adv; smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sub_done got %0d exp 0", state); end
    $display("rtype sub: completed, state=%0d", state);
  endtask

  task automatic test_branch;
    logic [5:0] ops [4];
    logic       zs  [4];
    logic [3:0] sts [4];
    logic       pcs [4];
    ops[0] = 6'b000101; zs[0] = 1'b1; sts[0] = 4'd9; pcs[0] = 1'b0;
    ops[1] = 6'b000101; zs[1] = 1'b0; sts[1] = 4'd9; pcs[1] = 1'b1;
    ops[2] = 6'b000100; zs[2] = 1'b1; sts[2] = 4'd8; pcs[2] = 1'b1;
    ops[3] = 6'b000100; zs[3] = 1'b0; sts[3] = 4'd8; pcs[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_fetch(ops[i], 6'd0);
      adv;
      zero = zs[i];
      smp;
      checks++; if (state !== sts[i] || PC_en !== pcs[i] || PCSource !== 2'd1 || ALU_operation !== 4'd6) begin errors++; $display("FAIL branch[%0d] got state=%0d PC_en=%b pcs=%0d op=%0d exp %0d %b 1 6", i, state, PC_en, PCSource, ALU_operation, sts[i], pcs[i]); end
      $display("branch op=%b zero=%b: state=%0d PC_en=%b", ops[i], zs[i], state, PC_en);
      adv; smp;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL branch_done[%0d] got %0d exp 0", i, state); end
    end
  endtask

  task automatic test_lw;
    do_fetch(6'b100011, 6'd0);
    adv; smp;
    checks++; if (state !== 4'd2 || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd2 || ALU_operation !== 4'd2) begin errors++; $display("FAIL lw_ma got state=%0d A=%0d B=%0d op=%0d", state, ALUSrcA, ALUSrcB, ALU_operation); end
    adv;
    for (int i = 0; i < 3; i++) begin
      MIO_ready = (i == 2);
      smp;
      checks++; if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0) begin errors++; $display("FAIL lw_mrd[%0d] got state=%0d MemRead=%b IorD=%b RegWrite=%b", i, state, MemRead, IorD, RegWrite); end
      adv;
    end
    MIO_ready = 1'b0;
    smp;
    checks++; if (state !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin errors++; $display("FAIL lw_lwb got state=%0d MemtoReg=%b RegWrite=%b RegDst=%b", state, MemtoReg, RegWrite, RegDst); end
    adv; smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_done got %0d exp 0", state); end
    $display("lw: completed, state=%0d", state);
  endtask

  task automatic test_imm;
    logic [5:0] ops [2];
    logic [3:0] alu [2];
    logic       zx  [2];
    ops[0] = 6'b001101; alu[0] = 4'd1; zx[0] = 1'b1;
    ops[1] = 6'b001010; alu[1] = 4'd7; zx[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_fetch(ops[i], 6'd0);
      adv; smp;
      checks++; if (state !== 4'd11 || ALU_operation !== alu[i] || ImmZext !== zx[i] || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd2) begin errors++; $display("FAIL imm_exe[%0d] got state=%0d op=%0d zext=%b A=%0d B=%0d exp 11 %0d %b 1 2", i, state, ALU_operation, ImmZext, ALUSrcA, ALUSrcB, alu[i], zx[i]); end
      adv; smp;
      checks++; if (state !== 4'd12 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin errors++; $display("FAIL imm_wb[%0d] got state=%0d RegWrite=%b RegDst=%b MemtoReg=%b", i, state, RegWrite, RegDst, MemtoReg); end
      $display("imm op=%b: alu=%0d zext=%b", ops[i], alu[i], zx[i]);
      adv;
    end
  endtask

  task automatic test_illegal;
    do_fetch(6'b111111, 6'd0);
    smp;
    checks++; if (illegal !== 1'b1 || {RegWrite, MemWrite, PC_en, IRWrite} !== 4'b0) begin errors++; $display("FAIL illegal_op got ill=%b strobes=%b exp 1 0000", illegal, {RegWrite, MemWrite, PC_en, IRWrite}); end
    adv; smp;
    checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL illegal_op_next got state=%0d ill=%b exp 0 0", state, illegal); end
    do_fetch(6'b000000, 6'b111111);
    adv; smp;
    checks++; if (state !== 4'd6 || illegal !== 1'b1 || RegWrite !== 1'b0) begin errors++; $display("FAIL illegal_funct got state=%0d ill=%b RegWrite=%b exp 6 1 0", state, illegal, RegWrite); end
    adv; smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL illegal_funct_next got %0d exp 0", state); end
    $display("illegal: opcode and funct cases done");
  endtask

  task automatic test_shift;
    logic [5:0] fns [2];
    logic [3:0] ops [2];
    fns[0] = 6'b000000; ops[0] = 4'd8;
    fns[1] = 6'b000010; ops[1] = 4'd5;
    for (int i = 0; i < 2; i++) begin
      do_fetch(6'b000000, fns[i]);
      smp;
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL shift_id[%0d] got ill=%b exp 0", i, illegal); end
      adv; smp;
`ifdef MCPU_SHIFT_EN
      checks++; if (state !== 4'd6 || ALU_operation !== ops[i] || ALUSrcA !== 2'd2 || ALUSrcB !== 2'd0 || illegal !== 1'b0) begin errors++; $display("FAIL shift_rexe[%0d] got state=%0d op=%0d A=%0d B=%0d ill=%b", i, state, ALU_operation, ALUSrcA, ALUSrcB, illegal); end
      adv; smp;
      checks++; if (state !== 4'd7 || RegWrite !== 1'b1) begin errors++; $display("FAIL shift_rwb[%0d] got state=%0d RegWrite=%b exp 7 1", i, state, RegWrite); end
      adv;
`else
      checks++; if (state !== 4'd6 || illegal !== 1'b1 || RegWrite !== 1'b0 || ALUSrcA !== 2'd1) begin errors++; $display("FAIL shift_undec[%0d] got state=%0d ill=%b RegWrite=%b A=%0d exp 6 1 0 1 (alu %0d unused)", i, state, illegal, RegWrite, ALUSrcA, ops[i]); end
      adv; smp;
      checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL shift_undec_next[%0d] got state=%0d ill=%b exp 0 0", i, state, illegal); end
`endif
      $display("shift funct=%b: checked", fns[i]);
    end
  endtask

  task automatic test_sw_reset;
    do_fetch(6'b101011, 6'd0);
    adv; adv;
    MIO_ready = 1'b1;
    smp;
    checks++; if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1) begin errors++; $display("FAIL sw_mwr got state=%0d MemWrite=%b IorD=%b exp 5 1 1", state, MemWrite, IorD); end
    adv; smp;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_done got %0d exp 0", state); end
    do_fetch(6'b101011, 6'd0);
    adv; adv; adv;
    smp;
    checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errors++; $display("FAIL sw_hold got state=%0d MemWrite=%b exp 5 1", state, MemWrite); end
    rst = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0 || state !== 4'd5) begin errors++; $display("FAIL sw_rst_mask got MemWrite=%b state=%0d exp 0 5", MemWrite, state); end
    adv;
    checks++; if (state !== 4'd0 || MemWrite !== 1'b0) begin errors++; $display("FAIL sw_rst_state got state=%0d MemWrite=%b exp 0 0", state, MemWrite); end
    rst = 1'b0;
    smp;
    checks++; if (state !== 4'd0 || IRWrite !== 1'b0) begin errors++; $display("FAIL sw_post_rst got state=%0d IRWrite=%b exp 0 0", state, IRWrite); end
    $display("sw: abort by reset in MWR, state=%0d", state);
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_rtype_sub;
    test_branch;
    test_lw;
    test_imm;
    test_illegal;
    test_shift;
    test_sw_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
